// File: rtl/alu_wb_stage.sv
// alu_wb_stage: capture stage that sits right after the ALU.
//
// Each accepted ALU result {in_y, in_dest} goes into a small FIFO. The FIFO
// head is offered to register-file writeback over a valid/ready handshake.
// The architectural status register (N, Z, C) is loaded from the most
// recently accepted result whose in_flag_we is set, in acceptance order.
//
// Optional feature (macro ALU_WB_BYPASS_EN):
//   When defined and the FIFO is empty, the incoming result is shown on out_*
//   combinationally. If writeback takes it in the same cycle, it is never
//   stored. When undefined, the stage has a fixed one-cycle latency and no
//   combinational path from in_* to out_*.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   in_valid   ALU result valid             in_ready   stage can accept
//   in_y       ALU result                   in_dest    destination register
//   in_n/z/c   ALU flags                    in_flag_we result updates status
//   out_valid  head entry available         out_ready  writeback consumes head
//   out_data   head result                  out_dest   head destination
//   status_n/z/c  registered status flags
//   count      number of occupied FIFO entries
module alu_wb_stage #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 2,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_y,
  input  logic              in_n,
  input  logic              in_z,
  input  logic              in_c,
  input  logic [ADDR_W-1:0] in_dest,
  input  logic              in_flag_we,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic [ADDR_W-1:0] out_dest,
  output logic              status_n,
  output logic              status_z,
  output logic              status_c,
  output logic [CNT_W-1:0]  count
);

  // Index bits address the storage; one extra wrap bit separates full from empty.
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PTR_W = IDX_W + 1;

  logic [WIDTH-1:0]  data_mem_q [DEPTH];
  logic [WIDTH-1:0]  data_mem_d [DEPTH];
  logic [ADDR_W-1:0] dest_mem_q [DEPTH];
  logic [ADDR_W-1:0] dest_mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [2:0]        status_q, status_d;

  logic [PTR_W-1:0]  occ_s;
  logic              empty_s;
  logic              full_s;
  logic              accept_s;
  logic              push_s;
  logic              pop_s;
  logic [IDX_W-1:0]  wr_idx_s;
  logic [IDX_W-1:0]  rd_idx_s;

  // Occupancy comes only from registered pointers, so in_ready never sees out_ready.
  assign occ_s    = wr_ptr_q - rd_ptr_q;
  assign empty_s  = (occ_s == {PTR_W{1'b0}});
  assign full_s   = (occ_s == PTR_W'(DEPTH));
  assign wr_idx_s = wr_ptr_q[IDX_W-1:0];
  assign rd_idx_s = rd_ptr_q[IDX_W-1:0];

  assign in_ready = !full_s;
  assign count    = CNT_W'(occ_s);
  assign accept_s = in_valid && in_ready;
  // A pop only ever removes a stored entry.
  assign pop_s    = !empty_s && out_ready;

`ifdef ALU_WB_BYPASS_EN
  logic bypass_s;
  // Result handed straight through when nothing is queued and writeback is ready.
  assign bypass_s  = empty_s && in_valid && out_ready;
  assign push_s    = accept_s && !bypass_s;
  assign out_valid = empty_s ? in_valid : 1'b1;
  assign out_data  = empty_s ? in_y     : data_mem_q[rd_idx_s];
  assign out_dest  = empty_s ? in_dest  : dest_mem_q[rd_idx_s];
`else
  assign push_s    = accept_s;
  assign out_valid = !empty_s;
  assign out_data  = data_mem_q[rd_idx_s];
  assign out_dest  = dest_mem_q[rd_idx_s];
`endif

  assign status_n = status_q[2];
  assign status_z = status_q[1];
  assign status_c = status_q[0];

  // Next-state: FIFO write, pointer advance and status load.
  always_comb begin
    data_mem_d = data_mem_q;
    dest_mem_d = dest_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    status_d   = status_q;

    if (push_s) begin
      data_mem_d[wr_idx_s] = in_y;
      dest_mem_d[wr_idx_s] = in_dest;
      wr_ptr_d             = wr_ptr_q + PTR_W'(1'b1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1'b1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    // Status follows acceptance order, including bypassed results.
    case ({accept_s, in_flag_we})
      2'b11:   status_d = {in_n, in_z, in_c};
      default: status_d = status_q;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_mem_q[i] <= {WIDTH{1'b0}};
        dest_mem_q[i] <= {ADDR_W{1'b0}};
      end
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      status_q <= 3'b000;
    end else begin
      data_mem_q <= data_mem_d;
      dest_mem_q <= dest_mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      status_q   <= status_d;
    end
  end

endmodule
